fetch_queue: RTL and testbench

Instruction fetch stage with a small prefetch queue, placed directly upstream of the decode/register-read stage of the pipelined processor. It drives the word-addressed instruction memory, buffers returned 16-bit instruction words with their PCs, and presents them to decode one instruction per handshake. An `li` instruction (opcode 4'hF) is presented together with its following immediate word. A redirect flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small prefetch queue feeding decode.
// An li opcode is presented together with its immediate word; redirect flushes and refetches.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        is_li,
  output logic [15:0] imm,
  output logic [4:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [3:0]  LI_OP = 4'hF;

  logic [15:0]      fetch_pc, fetch_pc_d;
  logic [15:0]      req_pc, req_pc_d;
  logic             pending, pending_d;
  logic [PTR_W-1:0] head, head_d;
  logic [PTR_W-1:0] tail, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic [1:0]       pop_n;
  logic [PTR_W-1:0] head_nxt;
  logic             has_head, has_pair;
  logic [OCC_W-1:0] occ;

  logic [15:0] pc_q   [DEPTH];
  logic [15:0] word_q [DEPTH];

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [SUM_W-1:0] s;
    s = {1'b0, p} + SUM_W'(n);
    if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Head presentation; outputs read zero whenever the queue is empty.
  assign head_nxt   = ptr_add(head, 2'd1);
  assign has_head   = (cnt_q != '0);
  assign has_pair   = (cnt_q >= CNT_W'(2));
  assign inst       = has_head ? word_q[head] : 16'h0000;
  assign inst_pc    = has_head ? pc_q[head] : 16'h0000;
  assign is_li      = has_head && (word_q[head][15:12] == LI_OP);
  assign imm        = (is_li && has_pair) ? word_q[head_nxt] : 16'h0000;
  assign inst_valid = !redirect && has_head && (!is_li || has_pair);
  assign count      = cnt_q;

  // Request only when the in-flight word is guaranteed a free slot.
  assign occ        = {1'b0, cnt_q} + OCC_W'(pending);
  assign imem_req   = reset && !redirect && !halt && (occ < OCC_W'(DEPTH));
  assign imem_addr  = fetch_pc;

  always_comb begin
    fetch_pc_d = fetch_pc;
    req_pc_d   = req_pc;
    pending_d  = imem_req;
    head_d     = head;
    tail_d     = tail;
    cnt_d      = cnt_q;
    push       = pending && !redirect;
    pop_n      = 2'd0;
    if (inst_valid && inst_ready) pop_n = is_li ? 2'd2 : 2'd1;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc + 16'd1;
        req_pc_d   = fetch_pc;
      end
      if (push) tail_d = ptr_add(tail, 2'd1);
      head_d = ptr_add(head, pop_n);
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      pending  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      cnt_q    <= '0;
    end else begin
      fetch_pc <= fetch_pc_d;
      req_pc   <= req_pc_d;
      pending  <= pending_d;
      head     <= head_d;
      tail     <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage needs no reset: visibility is governed by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]   <= req_pc;
      word_q[tail] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a 1-cycle-latency memory model.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        is_li;
  logic [15:0] imm;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_ovr [logic [15:0]];

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .is_li(is_li), .imm(imm), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default memory content is 16'h1000 + address unless overridden.
  function automatic logic [15:0] memword(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return 16'h1000 + a;
  endfunction

  always @(posedge clk) imem_data <= imem_req ? memword(imem_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    inst_ready  = 1'b1;

    // Reset state
    cyc();
    settle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_li", 32'(is_li), 32'd0);
    chk("rst_imm", 32'(imm), 32'd0);

    // Streaming from reset release, decode always ready
    mem_ovr.delete();
    inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      settle();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", 32'(imem_addr), 32'(c));
      if (c >= 2) begin
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_inst", 32'(inst), 32'(16'h1000 + 16'(c - 2)));
        chk("t1_pc", 32'(inst_pc), 32'(c - 2));
      end else begin
        chk("t1_nvalid", 32'(inst_valid), 32'd0);
      end
    end

    // Back-pressure fills the queue, then drains without gaps
    mem_ovr.delete();
    inst_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc();
      settle();
      if (c >= 5) chk("t2_noreq", 32'(imem_req), 32'd0);
    end
    chk("t2_full", 32'(count), 32'd4);
    chk("t2_hvalid", 32'(inst_valid), 32'd1);
    chk("t2_hinst", 32'(inst), 32'h1000);
    for (int c = 10; c < 15; c++) begin
      cyc();
      inst_ready = 1'b1;
      settle();
      chk("t2_valid", 32'(inst_valid), 32'd1);
      chk("t2_pc", 32'(inst_pc), 32'(c - 10));
      chk("t2_inst", 32'(inst), 32'(16'h1000 + 16'(c - 10)));
      if (c == 10) chk("t2_req10", 32'(imem_req), 32'd0);
      if (c == 11) begin
        chk("t2_req11", 32'(imem_req), 32'd1);
        chk("t2_addr11", 32'(imem_addr), 32'h0004);
      end
    end

    // li with immediate presented in a single handshake
    mem_ovr.delete();
    mem_ovr[16'h0002] = 16'hF005;
    mem_ovr[16'h0003] = 16'h1234;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) cyc();
    settle();
    chk("t3_wait_valid", 32'(inst_valid), 32'd0);
    chk("t3_wait_pc", 32'(inst_pc), 32'd2);
    chk("t3_wait_li", 32'(is_li), 32'd1);
    cyc();
    settle();
    chk("t3_valid", 32'(inst_valid), 32'd1);
    chk("t3_inst", 32'(inst), 32'hF005);
    chk("t3_li", 32'(is_li), 32'd1);
    chk("t3_imm", 32'(imm), 32'h1234);
    chk("t3_pc", 32'(inst_pc), 32'd2);
    cyc();
    settle();
    chk("t3_next_valid", 32'(inst_valid), 32'd1);
    chk("t3_next_pc", 32'(inst_pc), 32'd4);
    chk("t3_next_li", 32'(is_li), 32'd0);
    chk("t3_next_imm", 32'(imm), 32'd0);

    // li stalled behind halt until its immediate arrives
    mem_ovr.delete();
    mem_ovr[16'h0003] = 16'hF00A;
    inst_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) cyc();
    halt = 1'b1;
    settle();
    chk("t4_halt_req", 32'(imem_req), 32'd0);
    chk("t4_c4_valid", 32'(inst_valid), 32'd1);
    chk("t4_c4_pc", 32'(inst_pc), 32'd2);
    for (int c = 5; c <= 8; c++) begin
      cyc();
      settle();
      chk("t4_stall_valid", 32'(inst_valid), 32'd0);
      chk("t4_stall_pc", 32'(inst_pc), 32'd3);
      chk("t4_stall_li", 32'(is_li), 32'd1);
      chk("t4_stall_count", 32'(count), 32'd1);
      chk("t4_stall_req", 32'(imem_req), 32'd0);
    end
    cyc();
    halt = 1'b0;
    settle();
    chk("t4_resume_req", 32'(imem_req), 32'd1);
    chk("t4_resume_addr", 32'(imem_addr), 32'd4);
    chk("t4_c9_valid", 32'(inst_valid), 32'd0);
    cyc();
    settle();
    chk("t4_c10_valid", 32'(inst_valid), 32'd0);
    cyc();
    settle();
    chk("t4_valid", 32'(inst_valid), 32'd1);
    chk("t4_inst", 32'(inst), 32'hF00A);
    chk("t4_imm", 32'(imm), 32'h1004);
    chk("t4_pc", 32'(inst_pc), 32'd3);

    // Redirect with three queued entries and a response in flight
    mem_ovr.delete();
    inst_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 4; c++) cyc();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    settle();
    chk("t5_pre_count", 32'(count), 32'd3);
    chk("t5_rd_req", 32'(imem_req), 32'd0);
    chk("t5_rd_valid", 32'(inst_valid), 32'd0);
    cyc();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    settle();
    chk("t5_flush_count", 32'(count), 32'd0);
    chk("t5_k1_req", 32'(imem_req), 32'd1);
    chk("t5_k1_addr", 32'(imem_addr), 32'h0040);
    cyc();
    settle();
    chk("t5_k2_valid", 32'(inst_valid), 32'd0);
    cyc();
    settle();
    chk("t5_k3_valid", 32'(inst_valid), 32'd1);
    chk("t5_k3_pc", 32'(inst_pc), 32'h0040);
    chk("t5_k3_inst", 32'(inst), 32'h1040);
    cyc();
    settle();
    chk("t5_k4_pc", 32'(inst_pc), 32'h0041);

    // PC wrap past 16'hFFFF, then asynchronous reset mid-stream
    mem_ovr.delete();
    inst_ready = 1'b1;
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    settle();
    chk("t6_rd_req", 32'(imem_req), 32'd0);
    cyc();
    redirect = 1'b0;
    settle();
    chk("t6_addr_fffe", 32'(imem_addr), 32'hFFFE);
    cyc();
    settle();
    chk("t6_addr_ffff", 32'(imem_addr), 32'hFFFF);
    cyc();
    settle();
    chk("t6_addr_0000", 32'(imem_addr), 32'h0000);
    chk("t6_pc_fffe", 32'(inst_pc), 32'hFFFE);
    chk("t6_inst_fffe", 32'(inst), 32'h0FFE);
    cyc();
    settle();
    chk("t6_addr_0001", 32'(imem_addr), 32'h0001);
    chk("t6_pc_ffff", 32'(inst_pc), 32'hFFFF);
    cyc();
    settle();
    chk("t6_pc_0000", 32'(inst_pc), 32'h0000);
    chk("t6_inst_0000", 32'(inst), 32'h1000);
    cyc();
    settle();
    chk("t6_pre_count", 32'(count), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_valid", 32'(inst_valid), 32'd0);
    chk("t6_async_req", 32'(imem_req), 32'd0);
    cyc();
    reset = 1'b1;
    settle();
    chk("t6_restart_req", 32'(imem_req), 32'd1);
    chk("t6_restart_addr", 32'(imem_addr), 32'h0000);
    cyc();
    settle();
    chk("t6_restart_addr1", 32'(imem_addr), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
